// File: rtl/piso_sched_pkg.sv
// Shared types and sizing helpers for the PISO transmit scheduler.
package piso_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One counter width covers both the bit index (0..WIDTH-1) and the gap count (0..GAP_CYCLES-1).
  function automatic int cnt_width(input int width, input int gap_cycles);
    int span;
    span = (width > gap_cycles) ? width : gap_cycles;
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load, left-shifting register; load wins over shift.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= parallel_in;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin two-source arbiter and framing sequencer feeding a shared PISO shifter.
module piso_tx_scheduler
  import piso_sched_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [NREQ-1:0]  req_ready,
  input  logic             sout_ready,
  output logic             serial_out,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             sout_src,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH, GAP_CYCLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             src;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             grant_any;
  logic             grant_idx;
  logic             consume;
  logic             frame_end;
  logic             msb;
  logic [WIDTH-1:0] load_word;

  // Arbitration only happens in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    req_ready = '0;
    if (state == IDLE) begin
      case (req_valid)
        2'b01: begin
          grant_any = 1'b1;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
          grant_idx = ~last_grant;
        end
        default: ;
      endcase
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  assign load_word = grant_idx ? req_data1 : req_data0;
  assign consume   = (state == SHIFT) && sout_ready;
  assign frame_end = consume && (bit_cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      src        <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        last_grant <= grant_idx;
        src        <= grant_idx;
        bit_cnt    <= '0;
      end else if (consume) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (frame_end) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
    end
  end

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift_core (
    .clk        (clk),
    .reset      (reset),
    .load       (grant_any),
    .shift_en   (consume),
    .parallel_in(load_word),
    .msb        (msb)
  );

  // The shifter drains to zero by the end of each frame, so serial_out idles low.
  assign serial_out = msb;
  assign sout_valid = (state == SHIFT);
  assign sout_first = sout_valid && (bit_cnt == '0);
  assign sout_last  = sout_valid && (bit_cnt == LAST_IDX);
  assign sout_src   = src;
  assign busy       = (state != IDLE);

endmodule
